// File: rtl/spmv_pkg.sv
// Shared types and default widths for the SpMV network pack/op stages.
package spmv_pkg;

  localparam int unsigned SPMV_IN_WIDTH  = 32;
  localparam int unsigned SPMV_ID_WIDTH  = 8;
  localparam int unsigned SPMV_CNT_WIDTH = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

endpackage

// File: rtl/spmv_pair_reg.sv
// Output pair register: loads a new (a, b) pair when free, otherwise holds
// stable; clears lane valids on a handshake with nothing new to load.
module spmv_pair_reg #(
  parameter int unsigned IN_WIDTH = 32,
  parameter int unsigned ID_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [ID_WIDTH-1:0] a_id,
  input  logic [IN_WIDTH-1:0] a_val,
  input  logic [ID_WIDTH-1:0] b_id,
  input  logic [IN_WIDTH-1:0] b_val,
  input  logic                b_valid,
  input  logic                out_ready,
  output logic [ID_WIDTH-1:0] out_a_id,
  output logic [IN_WIDTH-1:0] out_a_val,
  output logic                out_a_valid,
  output logic [ID_WIDTH-1:0] out_b_id,
  output logic [IN_WIDTH-1:0] out_b_val,
  output logic                out_b_valid,
  output logic                out_free,
  output logic                fire
);

  logic out_occ;

  assign out_occ  = out_a_valid || out_b_valid;
  assign out_free = !out_occ || out_ready;
  assign fire     = out_occ && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_a_id    <= '0;
      out_a_val   <= '0;
      out_a_valid <= 1'b0;
      out_b_id    <= '0;
      out_b_val   <= '0;
      out_b_valid <= 1'b0;
    end else if (out_free) begin
      if (load) begin
        out_a_id    <= a_id;
        out_a_val   <= a_val;
        out_a_valid <= 1'b1;
        out_b_id    <= b_id;
        out_b_val   <= b_val;
        out_b_valid <= b_valid;
      end else begin
        out_a_valid <= 1'b0;
        out_b_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spmv_network_pack.sv
// Packs a single-element (id, val) stream into (a, b) lane pairs for the
// first spmv_network_op stage; odd tails leave with lane b invalid.
module spmv_network_pack
  import spmv_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = SPMV_IN_WIDTH,
  parameter int unsigned ID_WIDTH  = SPMV_ID_WIDTH,
  parameter int unsigned CNT_WIDTH = SPMV_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ID_WIDTH-1:0]  s_id,
  input  logic [IN_WIDTH-1:0]  s_val,
  input  logic                 s_last,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 flush,
  output logic [ID_WIDTH-1:0]  out_a_id,
  output logic [IN_WIDTH-1:0]  out_a_val,
  output logic                 out_a_valid,
  output logic [ID_WIDTH-1:0]  out_b_id,
  output logic [IN_WIDTH-1:0]  out_b_val,
  output logic                 out_b_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] pair_count
);

  pack_state_t         state;
  logic [ID_WIDTH-1:0] hold_id;
  logic [IN_WIDTH-1:0] hold_val;
  logic                pend_flush;

  logic                out_free;
  logic                fire;
  logic                accept;
  logic                load;
  logic [ID_WIDTH-1:0] ld_a_id;
  logic [IN_WIDTH-1:0] ld_a_val;
  logic [ID_WIDTH-1:0] ld_b_id;
  logic [IN_WIDTH-1:0] ld_b_val;
  logic                ld_b_valid;
  logic                flush_go;

  assign s_ready  = !rst && out_free;
  assign accept   = s_valid && s_ready;
  // A held flush only fires on a cycle with no accept; an accept pairs instead.
  assign flush_go = !accept && (flush || pend_flush) && out_free;

  always_comb begin
    load       = 1'b0;
    ld_a_id    = hold_id;
    ld_a_val   = hold_val;
    ld_b_id    = s_id;
    ld_b_val   = s_val;
    ld_b_valid = 1'b1;
    case (state)
      EMPTY: begin
        // Accepting with flush in EMPTY sends the element out alone, like s_last.
        if (accept && (s_last || flush)) begin
          load       = 1'b1;
          ld_a_id    = s_id;
          ld_a_val   = s_val;
          ld_b_id    = '0;
          ld_b_val   = '0;
          ld_b_valid = 1'b0;
        end
      end
      HALF: begin
        if (accept) begin
          load = 1'b1;
        end else if (flush_go) begin
          load       = 1'b1;
          ld_b_id    = '0;
          ld_b_val   = '0;
          ld_b_valid = 1'b0;
        end
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      hold_id    <= '0;
      hold_val   <= '0;
      pend_flush <= 1'b0;
      pair_count <= '0;
    end else begin
      if (fire) begin
        pair_count <= pair_count + 1'b1;
      end
      case (state)
        EMPTY: begin
          if (accept && !s_last && !flush) begin
            hold_id  <= s_id;
            hold_val <= s_val;
            state    <= HALF;
          end
        end
        HALF: begin
          if (accept || flush_go) begin
            hold_id    <= '0;
            hold_val   <= '0;
            pend_flush <= 1'b0;
            state      <= EMPTY;
          end else if (flush) begin
            pend_flush <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  spmv_pair_reg #(
    .IN_WIDTH(IN_WIDTH),
    .ID_WIDTH(ID_WIDTH)
  ) u_pair_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .a_id       (ld_a_id),
    .a_val      (ld_a_val),
    .b_id       (ld_b_id),
    .b_val      (ld_b_val),
    .b_valid    (ld_b_valid),
    .out_ready  (out_ready),
    .out_a_id   (out_a_id),
    .out_a_val  (out_a_val),
    .out_a_valid(out_a_valid),
    .out_b_id   (out_b_id),
    .out_b_val  (out_b_val),
    .out_b_valid(out_b_valid),
    .out_free   (out_free),
    .fire       (fire)
  );

endmodule
